// File: rtl/circuit_e.sv
// Three-input truth-table function with registered copy, rising-edge pulse and a
// saturating ones counter. Define CIRCUIT_E_HIST_EN to build the per-minterm histogram.
module circuit_e #(
    parameter logic [7:0] TRUTH_TABLE = 8'b1001_0110,
    parameter int         CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x,
    input  logic             y,
    input  logic             z,
    output logic             f,
    output logic             f_q,
    output logic             f_rise,
    output logic [CNT_W-1:0] ones_cnt,
    input  logic [2:0]       hist_sel,
    output logic [CNT_W-1:0] hist_q
);

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [2:0]       minterm;
    logic             f_q_q;
    logic             f_q_d;
    logic             f_rise_q;
    logic             f_rise_d;
    logic [CNT_W-1:0] ones_cnt_q;
    logic [CNT_W-1:0] ones_cnt_d;

    assign minterm = {x, y, z};
    assign f       = TRUTH_TABLE[minterm];

    // f_rise is registered so it lines up with the first cycle f_q reads 1.
    always_comb begin
        f_q_d      = f;
        f_rise_d   = f & ~f_q_q;
        ones_cnt_d = f ? sat_inc(ones_cnt_q) : ones_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_q_q      <= 1'b0;
            f_rise_q   <= 1'b0;
            ones_cnt_q <= '0;
        end else begin
            f_q_q      <= f_q_d;
            f_rise_q   <= f_rise_d;
            ones_cnt_q <= ones_cnt_d;
        end
    end

    assign f_q      = f_q_q;
    assign f_rise   = f_rise_q;
    assign ones_cnt = ones_cnt_q;

`ifdef CIRCUIT_E_HIST_EN
    logic [CNT_W-1:0] hist_cnt_q [8];
    logic [CNT_W-1:0] hist_cnt_d [8];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            hist_cnt_d[i] = (minterm == 3'(i)) ? sat_inc(hist_cnt_q[i]) : hist_cnt_q[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (!rst_n) begin
                hist_cnt_q[i] <= '0;
            end else begin
                hist_cnt_q[i] <= hist_cnt_d[i];
            end
        end
    end

    assign hist_q = hist_cnt_q[hist_sel];
`else
    logic unused_hist_sel;

    assign unused_hist_sel = ^hist_sel;
    assign hist_q          = '0;
`endif

endmodule

// File: tb/tb_circuit_e.sv
// Directed bench for circuit_e: a default instance plus a narrow-counter,
// single-minterm instance sharing the same stimulus.
module tb_circuit_e;

    localparam logic [7:0] TT_DEF = 8'b1001_0110;
    localparam logic [7:0] TT_AND = 8'b1000_0000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       x, y, z;
    logic [2:0] hist_sel;

    logic       f, f_q, f_rise;
    logic [7:0] ones_cnt, hist_q;
    logic       s_f, s_f_q, s_f_rise;
    logic [3:0] s_ones_cnt, s_hist_q;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    circuit_e dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .z(z),
        .f(f), .f_q(f_q), .f_rise(f_rise), .ones_cnt(ones_cnt),
        .hist_sel(hist_sel), .hist_q(hist_q)
    );

    circuit_e #(.TRUTH_TABLE(TT_AND), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .z(z),
        .f(s_f), .f_q(s_f_q), .f_rise(s_f_rise), .ones_cnt(s_ones_cnt),
        .hist_sel(hist_sel), .hist_q(s_hist_q)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic [2:0] m);
        {x, y, z} = m;
    endtask

    function automatic int hist_exp(input logic [2:0] sel, input logic [2:0] m, input int n);
`ifdef CIRCUIT_E_HIST_EN
        return (sel == m) ? n : 0;
`else
        return 0;
`endif
    endfunction

    initial begin
        rst_n    = 1'b0;
        hist_sel = 3'd0;
        set_m(3'b000);
        tick();
        tick();

        check("rst_f_q", int'(f_q), 0);
        check("rst_f_rise", int'(f_rise), 0);
        check("rst_ones", int'(ones_cnt), 0);
        check("rst_hist", int'(hist_q), 0);

        // combinational sweep while held in reset
        for (int m = 0; m < 8; m++) begin
            set_m(3'(m));
            #1;
            check($sformatf("f_def_m%0d", m), int'(f), int'(TT_DEF[m]));
            check($sformatf("f_and_m%0d", m), int'(s_f), (m == 7) ? 1 : 0);
        end

        // hold 100 through the release of reset
        set_m(3'b100);
        tick();
        check("in_rst_f_q", int'(f_q), 0);
        rst_n = 1'b1;
        tick();
        check("c1_f_q", int'(f_q), 1);
        check("c1_f_rise", int'(f_rise), 1);
        check("c1_ones", int'(ones_cnt), 1);
        tick();
        check("c2_f_rise", int'(f_rise), 0);
        check("c2_ones", int'(ones_cnt), 2);
        tick();
        check("c3_f_q", int'(f_q), 1);
        check("c3_ones", int'(ones_cnt), 3);
        check("c3_s_ones", int'(s_ones_cnt), 0);
        hist_sel = 3'd4;
        #1;
        check("c3_hist4", int'(hist_q), hist_exp(3'd4, 3'd4, 3));

        set_m(3'b000);
        tick();
        check("f0_f_q", int'(f_q), 0);
        check("f0_ones", int'(ones_cnt), 3);

        // mid-count reset at ones_cnt=5
        set_m(3'b001);
        tick();
        tick();
        check("pre_rst_ones", int'(ones_cnt), 5);
        rst_n = 1'b0;
        tick();
        check("mid_rst_ones", int'(ones_cnt), 0);
        check("mid_rst_f_q", int'(f_q), 0);
        check("mid_rst_f_rise", int'(f_rise), 0);
        for (int s = 0; s < 8; s++) begin
            hist_sel = 3'(s);
            #1;
            check($sformatf("mid_rst_hist%0d", s), int'(hist_q), 0);
        end
        rst_n = 1'b1;
        tick();
        check("resume_ones", int'(ones_cnt), 1);
        check("resume_f_rise", int'(f_rise), 1);

        // histogram: 011 x4, 110 x2
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_m(3'b011);
        repeat (4) tick();
        set_m(3'b110);
        repeat (2) tick();
        check("hist_ones", int'(ones_cnt), 0);
        for (int s = 0; s < 8; s++) begin
            hist_sel = 3'(s);
            #1;
            check($sformatf("hist_sel%0d", s), int'(hist_q),
                  hist_exp(3'(s), 3'd3, 4) + hist_exp(3'(s), 3'd6, 2));
        end

        // saturation: 111 for 20 cycles
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_m(3'b111);
        repeat (20) tick();
        check("sat_s_ones", int'(s_ones_cnt), 15);
        check("sat_ones", int'(ones_cnt), 20);
        check("sat_s_f_rise", int'(s_f_rise), 0);
        hist_sel = 3'd7;
        #1;
        check("sat_hist7", int'(hist_q), hist_exp(3'd7, 3'd7, 20));
        check("sat_s_hist7", int'(s_hist_q), hist_exp(3'd7, 3'd7, 15));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/circuit_e.md
CIRCUIT_E -- requirements
Module: circuit_e

Interface
REQ-001 Parameter TRUTH_TABLE, default 8'b1001_0110, sets f for minterm m={x,y,z} (x MSB); the default is odd parity.
REQ-002 Parameter CNT_W, default 8, sets the width of all counters.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, reset; synchronous and active-low.
REQ-005 Port x, input, 1, function operand, MSB of minterm index.
REQ-006 Port y, input, 1, function operand, middle bit of minterm index.
REQ-007 Port z, input, 1, function operand, LSB of minterm index.
REQ-008 Port f, output, 1, combinational function result.
REQ-009 Port f_q, output, 1, f registered once.
REQ-010 Port f_rise, output, 1, one-cycle pulse on a 0->1 transition of f_q.
REQ-011 Port ones_cnt, output, CNT_W, count of cycles in which f was sampled as 1.
REQ-012 Port hist_sel, input, 3, selects the minterm whose histogram count is read.
REQ-013 Port hist_q, output, CNT_W, histogram count for minterm hist_sel.

Function
REQ-014 f shall equal TRUTH_TABLE[{x,y,z}] with zero latency and no dependence on clk or rst_n.
REQ-015 f_q shall take the value of f on each rising clk edge, giving 1-cycle latency.
REQ-016 f_rise shall be 1 for exactly the cycle after f_q changes from 0 to 1; it shall be 0 otherwise, including for a 1->1 hold.
REQ-017 ones_cnt shall increment by 1 on each edge where f=1 and shall saturate at all-ones with no wrap.
REQ-018 When x, y and z change in the same cycle, only the final minterm shall be evaluated; no intermediate glitch state shall be registered.
REQ-019 All arithmetic shall be unsigned, CNT_W bits wide, and saturating.
REQ-020 hist_q shall be a combinational read of the selected counter.

Reset
REQ-021 While rst_n=0 at a rising clk edge, f_q, f_rise, ones_cnt and all histogram counters shall be cleared to 0.
REQ-022 f shall remain valid during reset.
REQ-023 A reset asserted mid-count shall clear counts on that edge; counting shall resume on the first edge with rst_n=1.

Configuration
REQ-024 With macro CIRCUIT_E_HIST_EN defined, eight saturating CNT_W counters shall exist, and counter m shall increment on each non-reset edge where {x,y,z}=m.
REQ-025 Without CIRCUIT_E_HIST_EN, no histogram counters shall be built, hist_q shall be tied to 0, and hist_sel shall be ignored.
REQ-026 All other behaviour shall be identical with and without the macro.

Verification
REQ-027 Sweep {x,y,z}=000..111, one step per unit, default TRUTH_TABLE -> f = 0,1,1,0,1,0,0,1 in the same step.
REQ-028 Reset for 2 cycles, then hold x=1,y=0,z=0 for 3 cycles:
- f_q=1 from cycle 1 after reset.
- f_rise=1 in that cycle only.
- ones_cnt=3.
REQ-029 CNT_W=4, hold f=1 for 20 cycles -> ones_cnt saturates at 15.
REQ-030 Assert rst_n=0 for one edge while ones_cnt=5 -> all counters=0, f_q=0, f_rise=0 next cycle.
REQ-031 CIRCUIT_E_HIST_EN defined, apply minterm 011 for 4 cycles and 110 for 2 cycles -> hist_q=4 at hist_sel=3, 2 at hist_sel=6, 0 elsewhere; macro undefined -> hist_q=0 for all hist_sel.
REQ-032 TRUTH_TABLE=8'b1000_0000, sweep all minterms -> f=1 only at 111.
